// File: rtl/histogram_sequencer.sv
// Frame controller: clears histogram_unit, streams N_SAMPLES samples in, then reads back every bin.
// Latency: sample -> hu_ena 1 cycle; bin readout 3 cycles per bin (address, read wait, present).
// Backpressure: s_ready low outside ACCUM; m_valid holds m_bin/m_count stable until m_ready.
module histogram_sequencer #(
    parameter int SIZE       = 7,
    parameter int MAX_NUMBER = 127,
    parameter int DW         = $clog2(MAX_NUMBER),
    parameter int N_SAMPLES  = 1024
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            abort,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [DW-1:0]   hu_d_in,
    output logic            hu_ena,
    output logic            hu_clr,
    input  logic [SIZE-1:0] hu_mem_out,
    output logic [DW-1:0]   m_bin,
    output logic [SIZE-1:0] m_count,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic            busy,
    output logic            done,
    output logic            oor_flag
);

    localparam int          CW    = $clog2(N_SAMPLES + 1);
    localparam logic [31:0] MAX_U = 32'(MAX_NUMBER);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        RADDR = 3'd4,
        RWAIT = 3'd5,
        ROUT  = 3'd6
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  samp_cnt;
    logic [DW-1:0]  bin_cnt;
    logic           s_hs;
    logic           m_hs;
    logic           last_samp;
    logic           last_bin;
    logic           samp_oor;

    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid && m_ready && !abort;
    assign last_samp = (samp_cnt == CW'(N_SAMPLES - 1));
    assign last_bin  = (bin_cnt == DW'(MAX_NUMBER));
    assign samp_oor  = ({{(32-DW){1'b0}}, s_data} > MAX_U);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = CLEAR;
                CLEAR:   state_nxt = ACCUM;
                ACCUM:   if (s_hs && last_samp) state_nxt = DRAIN;
                DRAIN:   state_nxt = RADDR;
                RADDR:   state_nxt = RWAIT;
                RWAIT:   state_nxt = ROUT;
                ROUT:    if (m_hs) state_nxt = last_bin ? IDLE : RADDR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // abort masks s_ready in the same cycle so no sample is swallowed by a cancelled frame
    always_comb begin
        s_ready = (state == ACCUM) && !abort;
        hu_clr  = (state == CLEAR);
        m_valid = (state == ROUT);
        m_last  = (state == ROUT) && last_bin;
        busy    = (state != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_cnt <= '0;
            bin_cnt  <= '0;
            hu_d_in  <= '0;
            hu_ena   <= 1'b0;
            m_bin    <= '0;
            m_count  <= '0;
            done     <= 1'b0;
            oor_flag <= 1'b0;
        end else begin
            hu_ena <= 1'b0;
            done   <= 1'b0;
            if (!abort) begin
                case (state)
                    IDLE: begin
                        if (start) oor_flag <= 1'b0;
                    end
                    CLEAR: begin
                        samp_cnt <= '0;
                    end
                    ACCUM: begin
                        if (s_hs) begin
                            samp_cnt <= samp_cnt + 1'b1;
                            hu_d_in  <= s_data;
                            hu_ena   <= !samp_oor;
                            if (samp_oor) oor_flag <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        bin_cnt <= '0;
                        hu_d_in <= '0;
                    end
                    RWAIT: begin
                        m_count <= hu_mem_out;
                        m_bin   <= bin_cnt;
                    end
                    ROUT: begin
                        if (m_hs) begin
                            if (last_bin) begin
                                done <= 1'b1;
                            end else begin
                                bin_cnt <= bin_cnt + 1'b1;
                                hu_d_in <= bin_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_histogram_sequencer.sv
// Bench for histogram_sequencer: two instances (default, and MAX_NUMBER=100/N_SAMPLES=24)
// each driving a behavioural histogram_unit; results checked against a scoreboard queue.
module tb_histogram_sequencer;

    typedef struct packed {
        logic [6:0] bin;
        logic [6:0] cnt;
        logic       last;
    } res_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start0, start1, abort, s_valid, m_ready;
    logic [6:0] s_data;

    logic [1:0] s_rdy, hu_ena, hu_clr, m_vld, m_lst, busy, done, oor;
    logic [6:0] hu_d   [2];
    logic [6:0] hu_mem [2];
    logic [6:0] m_bin  [2];
    logic [6:0] m_cnt  [2];
    logic [6:0] hmem   [2][128];

    int   errors = 0;
    int   n_checks = 0;
    int   sel = 0;
    bit   hs;
    int   exp_h [128];
    res_t q0 [$];
    res_t q1 [$];
    bit         hold [2];
    logic [6:0] hold_bin [2];
    logic [6:0] hold_cnt [2];
    bit         pend_done [2];
    int   done_cnt [2];
    int   ena_cnt [2];
    int   pops [2];
    int   done_base [2];
    int   ena_base [2];
    int   pop_base [2];

    always #5 CLK = ~CLK;

    histogram_sequencer u_dut0 (
        .CLK(CLK), .RST(RST), .start(start0), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_rdy[0]),
        .hu_d_in(hu_d[0]), .hu_ena(hu_ena[0]), .hu_clr(hu_clr[0]), .hu_mem_out(hu_mem[0]),
        .m_bin(m_bin[0]), .m_count(m_cnt[0]), .m_valid(m_vld[0]), .m_ready(m_ready),
        .m_last(m_lst[0]), .busy(busy[0]), .done(done[0]), .oor_flag(oor[0])
    );

    histogram_sequencer #(.MAX_NUMBER(100), .N_SAMPLES(24)) u_dut1 (
        .CLK(CLK), .RST(RST), .start(start1), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_rdy[1]),
        .hu_d_in(hu_d[1]), .hu_ena(hu_ena[1]), .hu_clr(hu_clr[1]), .hu_mem_out(hu_mem[1]),
        .m_bin(m_bin[1]), .m_count(m_cnt[1]), .m_valid(m_vld[1]), .m_ready(m_ready),
        .m_last(m_lst[1]), .busy(busy[1]), .done(done[1]), .oor_flag(oor[1])
    );

    // behavioural histogram_unit: saturating bins, registered 1-cycle read
    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (hu_clr[d]) begin
                for (int k = 0; k < 128; k++) hmem[d][k] <= '0;
            end else if (hu_ena[d] && hmem[d][hu_d[d]] != 7'h7f) begin
                hmem[d][hu_d[d]] <= hmem[d][hu_d[d]] + 7'd1;
            end
            hu_mem[d] <= hmem[d][hu_d[d]];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int maxv(input int d);
        return (d == 1) ? 100 : 127;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start0 = v;
        else        start1 = v;
    endtask

    // one clock: observe at the falling edge, return just after the rising edge
    task automatic cycle();
        res_t got;
        res_t exp;
        int   qs;
        @(negedge CLK);
        hs = s_valid && s_rdy[sel];
        for (int d = 0; d < 2; d++) begin
            if (hold[d])
                chk("hold_stable", {m_vld[d], m_bin[d], m_cnt[d]}, {1'b1, hold_bin[d], hold_cnt[d]});
            hold[d]     = m_vld[d] && !m_ready;
            hold_bin[d] = m_bin[d];
            hold_cnt[d] = m_cnt[d];
            if (pend_done[d]) chk("done_pulse", done[d], 1);
            pend_done[d] = m_vld[d] && m_ready && m_lst[d];
            if (done[d])   done_cnt[d]++;
            if (hu_ena[d]) ena_cnt[d]++;
            if (m_vld[d] && m_ready) begin
                pops[d]++;
                qs = (d == 0) ? q0.size() : q1.size();
                chk("sb_avail", qs > 0, 1);
                if (qs > 0) begin
                    exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                    got.bin  = m_bin[d];
                    got.cnt  = m_cnt[d];
                    got.last = m_lst[d];
                    chk("result", got, exp);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input int d);
        chk("rst_ctl", {s_rdy[d], hu_ena[d], hu_clr[d], m_vld[d], m_lst[d], busy[d], done[d], oor[d]}, 0);
        chk("rst_hu_d_in", hu_d[d], 0);
        chk("rst_m_bin", m_bin[d], 0);
        chk("rst_m_count", m_cnt[d], 0);
    endtask

    task automatic start_frame(input int d);
        foreach (exp_h[k]) exp_h[k] = 0;
        done_base[d] = done_cnt[d];
        ena_base[d]  = ena_cnt[d];
        pop_base[d]  = pops[d];
        set_start(d, 1'b1);
        cycle();
        set_start(d, 1'b0);
        chk("clr_pulse", {hu_clr[d], busy[d], oor[d], s_rdy[d]}, 4'b1100);
        cycle();
        chk("clr_single", {hu_clr[d], s_rdy[d]}, 2'b01);
    endtask

    task automatic send(input int d, input int val, input bit gap);
        int t = 0;
        s_data  = 7'(val);
        s_valid = 1'b1;
        cycle();
        while (!hs && t < 50) begin
            cycle();
            t++;
        end
        chk("sample_accepted", hs, 1);
        if (hs && val <= maxv(d)) exp_h[val]++;
        s_valid = 1'b0;
        if (gap) cycle();
    endtask

    task automatic push_exp(input int d);
        res_t e;
        for (int b = 0; b <= maxv(d); b++) begin
            e.bin  = 7'(b);
            e.cnt  = (exp_h[b] > 127) ? 7'd127 : 7'(exp_h[b]);
            e.last = (b == maxv(d));
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic wait_frame(input int d, input bit bp, input bit poke);
        int t = 0;
        m_ready = !bp;
        while (busy[d] && t < 3000) begin
            if (bp && m_vld[d]) begin
                if (poke) set_start(d, 1'b1);
                cycle();
                set_start(d, 1'b0);
                repeat (4) cycle();
                m_ready = 1'b1;
                cycle();
                m_ready = 1'b0;
                t += 6;
            end else begin
                cycle();
                t++;
            end
        end
        chk("frame_complete", busy[d], 0);
        m_ready = 1'b0;
        cycle();
    endtask

    task automatic end_checks(input int d, input int nres, input int nena);
        chk("result_count", pops[d] - pop_base[d], nres);
        chk("done_count", done_cnt[d] - done_base[d], 1);
        chk("sb_drained", (d == 0) ? q0.size() : q1.size(), 0);
        chk("ena_count", ena_cnt[d] - ena_base[d], nena);
    endtask

    initial begin
        start0 = 0; start1 = 0; abort = 0; s_valid = 0; s_data = '0; m_ready = 0;
        for (int d = 0; d < 2; d++) begin
            hold[d] = 0; pend_done[d] = 0; done_cnt[d] = 0; ena_cnt[d] = 0; pops[d] = 0;
        end
        #1 RST = 1'b0;
        #2;
        chk_reset(0);
        chk_reset(1);
        #14 RST = 1'b1;
        cycle();

        // even values wrapped to 7 bits, back-to-back, m_ready held high
        sel = 0;
        start_frame(0);
        for (int i = 0; i < 1024; i++) send(0, (2 * i) % 128, 1'b0);
        push_exp(0);
        wait_frame(0, 1'b0, 1'b0);
        end_checks(0, 128, 1024);
        chk("oor_clean", oor[0], 0);

        // same data with valid gaps, 5-cycle backpressure and start pokes during readout
        start_frame(0);
        for (int i = 0; i < 1024; i++) send(0, (2 * i) % 128, 1'b1);
        push_exp(0);
        wait_frame(0, 1'b1, 1'b1);
        end_checks(0, 128, 1024);

        // abort on the 500th sample, then a fresh frame
        start_frame(0);
        for (int i = 0; i < 499; i++) send(0, (2 * i) % 128, 1'b0);
        s_data = 7'd3; s_valid = 1'b1; abort = 1'b1;
        cycle();
        chk("abort_blocks_sample", hs, 0);
        abort = 1'b0; s_valid = 1'b0;
        chk("abort_idle", {busy[0], s_rdy[0], hu_ena[0], m_vld[0]}, 0);
        repeat (3) cycle();
        chk("abort_no_done", done_cnt[0] - done_base[0], 0);
        start_frame(0);
        for (int i = 0; i < 1024; i++) send(0, i % 128, 1'b0);
        push_exp(0);
        wait_frame(0, 1'b0, 1'b0);
        end_checks(0, 128, 1024);

        // reduced instance: out-of-range samples counted but not binned
        sel = 1;
        start_frame(1);
        for (int i = 0; i < 10; i++) send(1, 120, 1'b0);
        chk("oor_set", oor[1], 1);
        for (int i = 0; i < 14; i++) send(1, 5, 1'b0);
        push_exp(1);
        wait_frame(1, 1'b0, 1'b0);
        end_checks(1, 101, 14);
        chk("oor_sticky", oor[1], 1);

        // asynchronous reset in the middle of ACCUM
        sel = 0;
        start_frame(0);
        for (int i = 0; i < 10; i++) send(0, 2 * i + 1, 1'b0);
        done_base[0] = done_cnt[0];
        done_base[1] = done_cnt[1];
        s_data = 7'd99; s_valid = 1'b1;
        #1 RST = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        s_valid = 1'b0;
        cycle();
        cycle();
        RST = 1'b1;
        repeat (2) cycle();
        chk("post_reset_idle", busy, 0);
        chk("reset_no_done0", done_cnt[0] - done_base[0], 0);
        chk("reset_no_done1", done_cnt[1] - done_base[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
